vr_control: RTL and testbench
=============================

# vr_control

Instruction sequencer for the VeriRISC CPU. It steps an 8-phase state machine per instruction and decodes the current `opcode` (`opcode_t` from `typedefs`) and the ALU `zero` flag. From these it drives the memory, instruction register, accumulator and program counter control strobes. The `alu` block, the accumulator and the PC register operate on the strobes it issues.

## Interface
- `STICKY_HALT`, default 1. Sets what happens on HLT:
  - 1: the sequencer freezes until reset.
  - 0: `halt` pulses for one cycle in OP_ADDR and sequencing continues.
- `clk` in 1: the single clock. Everything updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 3 (`opcode_t`): current instruction register opcode.
- `zero` in 1: ALU accumulator-zero flag.
- `mem_rd` out 1: memory read enable.
- `mem_wr` out 1: memory write enable.
- `load_ir` out 1: instruction register load.
- `load_ac` out 1: accumulator load.
- `load_pc` out 1: program counter load (jump).
- `inc_pc` out 1: program counter increment.
- `data_e` out 1: data bus drive enable for STO.
- `halt` out 1: CPU halted indication.
- `phase` out 3: current state encoding, for debug and the bench.

## Operation
- States, in encoding order 0..7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- Transitions: each state advances to the next on every posedge; STORE wraps to INST_ADDR. There is no other branching, except the halt freeze below.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Output decode. Outputs are combinational from state, opcode, zero and halted. Any strobe not listed for a state is 0.
  - INST_ADDR: all 0.
  - INST_FETCH: `mem_rd`.
  - INST_LOAD, IDLE: `mem_rd`, `load_ir`.
  - OP_ADDR: `inc_pc`, `halt` = (opcode==HLT).
  - OP_FETCH: `mem_rd` = ALUOP.
  - ALU_OP:
    - `mem_rd`, `load_ac` = ALUOP.
    - `inc_pc` = (opcode==SKZ && zero).
    - `load_pc` = (opcode==JMP).
    - `data_e` = (opcode==STO).
  - STORE:
    - `mem_rd`, `load_ac` = ALUOP.
    - `inc_pc`, `load_pc` = (opcode==JMP).
    - `data_e`, `mem_wr` = (opcode==STO).
- Halt with STICKY_HALT=1:
  - In OP_ADDR with opcode==HLT: `halt`=1, `inc_pc`=0, and the halted register is set at the next posedge.
  - While halted: `phase` holds at OP_ADDR (4), `halt`=1, all other strobes 0, regardless of opcode or zero.
  - Only `rst` clears halted.
- Halt with STICKY_HALT=0: the OP_ADDR decode above applies unchanged (`inc_pc`=1 and `halt`=1 for that one cycle), then sequencing continues.
- `mem_wr` and `mem_rd` are never asserted together.

## Timing
- Reset:
  - While `rst`=1 at a posedge, the state goes to INST_ADDR and halted clears.
  - All outputs are then 0 and `phase`=0.
  - The first posedge with `rst`=0 moves to INST_FETCH.
- Reset has priority over everything, including mid-instruction and while halted.
- One instruction takes exactly 8 clocks. The strobes are valid for the full cycle of their state. Sequential consumers (IR, AC, PC, memory) sample at the posedge that ends the state.
- `opcode` must be stable from OP_ADDR through STORE. IR loads only in INST_LOAD/IDLE.
- `zero` is used combinationally during ALU_OP only. The ALU result updates on negedge inside OP_FETCH and ALU_OP, so the `load_ac` capture at the end of STORE sees a settled `out`.
- No input-to-output registers: strobes change within a cycle of a `phase` change. Only `phase` and halted are flops.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with opcode=ADD.
  - Required: `phase`=0 and all outputs 0.
  - After release, the next cycle shows `phase`=1 and `mem_rd`=1.
- ADD full instruction. Required per-cycle strobes, phases 0..7:
  - 0: none
  - 1: rd
  - 2: rd+ir
  - 3: rd+ir
  - 4: inc
  - 5: rd
  - 6: rd+ac
  - 7: rd+ac
  - Then `phase` returns to 0. `mem_wr`, `load_pc` and `data_e` stay 0 throughout.
- SKZ:
  - With zero=1: `inc_pc`=1 in ALU_OP.
  - Repeat with zero=0: `inc_pc`=0 in ALU_OP.
  - In both runs: `inc_pc`=1 in OP_ADDR, and `load_ac`=0 throughout.
- JMP then STO:
  - JMP: `load_pc`=1 in ALU_OP and STORE, and `inc_pc`=1 in STORE.
  - STO: `data_e`=1 in ALU_OP and STORE, `mem_wr`=1 only in STORE, and `mem_rd`=0 in phases 5–7.
- HLT with STICKY_HALT=1:
  - At `phase`=4: `halt`=1 and `inc_pc`=0.
  - For the next 20 cycles: `phase` stays 4, `halt`=1 and all strobes 0, even with opcode changed to ADD and zero toggled.
  - Pulse `rst` for 1 cycle: `phase`=0 and `halt`=0.
- Reset mid-operation: assert `rst` for 1 cycle during ALU_OP with opcode=LDA.
  - Required: the next cycle shows `phase`=0 and all outputs 0.
  - A normal 8-cycle sequence resumes afterwards.

Source files
------------

// File: rtl/vr_control_if.sv
// Control bus between the VeriRISC sequencer and its datapath.
// The sequencer takes the master side; the datapath or a bench takes the slave side.
interface vr_control_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       load_ac;
  logic       load_pc;
  logic       inc_pc;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt, phase
  );
endinterface

// File: rtl/vr_control.sv
// VeriRISC instruction sequencer: eight-phase state machine per instruction
// with combinational strobe decode from phase, opcode, zero and halted.
package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module vr_control
  import typedefs::*;
#(
  parameter bit STICKY_HALT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  vr_control_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_e;

  state_e  state_q, state_d;
  logic    halted_q, halted_d;
  opcode_t opcode_s;
  logic    aluop_s, hlt_s, skz_s, jmp_s, sto_s;
  logic    mem_rd_s, mem_wr_s, load_ir_s, load_ac_s, load_pc_s, inc_pc_s, data_e_s, halt_s;

  assign opcode_s = opcode_t'(bus.opcode);
  assign aluop_s  = (opcode_s == ADD) || (opcode_s == AND) ||
                    (opcode_s == XOR) || (opcode_s == LDA);
  assign hlt_s    = (opcode_s == HLT);
  assign skz_s    = (opcode_s == SKZ);
  assign jmp_s    = (opcode_s == JMP);
  assign sto_s    = (opcode_s == STO);

  // State and halted flops; reset wins over everything, including a frozen halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next state: linear walk through the phases, frozen at OP_ADDR on a sticky HLT.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (halted_q) begin
      state_d = state_q;
    end else if (STICKY_HALT && (state_q == OP_ADDR) && hlt_s) begin
      halted_d = 1'b1;
      state_d  = OP_ADDR;
    end else begin
      case (state_q)
        INST_ADDR:  state_d = INST_FETCH;
        INST_FETCH: state_d = INST_LOAD;
        INST_LOAD:  state_d = IDLE;
        IDLE:       state_d = OP_ADDR;
        OP_ADDR:    state_d = OP_FETCH;
        OP_FETCH:   state_d = ALU_OP;
        ALU_OP:     state_d = STORE;
        STORE:      state_d = INST_ADDR;
        default:    state_d = INST_ADDR;
      endcase
    end
  end

  // Strobe decode; a halted sequencer shows only halt regardless of its inputs.
  always_comb begin
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    load_ir_s = 1'b0;
    load_ac_s = 1'b0;
    load_pc_s = 1'b0;
    inc_pc_s  = 1'b0;
    data_e_s  = 1'b0;
    halt_s    = 1'b0;
    if (halted_q) begin
      halt_s = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: begin
          mem_rd_s = 1'b0;
        end
        INST_FETCH: begin
          mem_rd_s = 1'b1;
        end
        INST_LOAD, IDLE: begin
          mem_rd_s  = 1'b1;
          load_ir_s = 1'b1;
        end
        OP_ADDR: begin
          // A sticky HLT must not advance the PC past the halt instruction.
          inc_pc_s = !(STICKY_HALT && hlt_s);
          halt_s   = hlt_s;
        end
        OP_FETCH: begin
          mem_rd_s = aluop_s;
        end
        ALU_OP: begin
          mem_rd_s  = aluop_s;
          load_ac_s = aluop_s;
          inc_pc_s  = skz_s && bus.zero;
          load_pc_s = jmp_s;
          data_e_s  = sto_s;
        end
        STORE: begin
          mem_rd_s  = aluop_s;
          load_ac_s = aluop_s;
          inc_pc_s  = jmp_s;
          load_pc_s = jmp_s;
          data_e_s  = sto_s;
          mem_wr_s  = sto_s;
        end
        default: begin
          mem_rd_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd  = mem_rd_s;
  assign bus.mem_wr  = mem_wr_s;
  assign bus.load_ir = load_ir_s;
  assign bus.load_ac = load_ac_s;
  assign bus.load_pc = load_pc_s;
  assign bus.inc_pc  = inc_pc_s;
  assign bus.data_e  = data_e_s;
  assign bus.halt    = halt_s;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_vr_control.sv
// Bench for vr_control: sticky and non-sticky instances share stimulus and are
// each checked every cycle against a phase-counter model of the sequencer.
module tb_vr_control;
  import typedefs::*;

  logic       clk;
  logic       rst;
  logic [2:0] op_r;
  logic       zero_r;
  int         compared;
  int         mismatched;

  // Model state per instance: phase number and halted flag.
  int ph_s, ph_n;
  bit hl_s, hl_n;

  vr_control_if bus_s ();
  vr_control_if bus_n ();

  assign bus_s.opcode = op_r;
  assign bus_s.zero   = zero_r;
  assign bus_n.opcode = op_r;
  assign bus_n.zero   = zero_r;

  vr_control #(.STICKY_HALT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  vr_control #(.STICKY_HALT(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {rd, wr, ir, ac, pc, inc, de, halt} from the instruction-cycle rules.
  function automatic logic [7:0] expect_strobes(input int ph, input logic [2:0] op,
                                                input logic z, input bit halted,
                                                input bit sticky);
    bit alu, rd, wr, ir, ac, pc, inc, de, hl;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    if (halted) return 8'b0000_0001;
    rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    wr  = (ph == 7) && (op == STO);
    ir  = (ph == 2) || (ph == 3);
    ac  = (ph >= 6) && alu;
    pc  = (ph >= 6) && (op == JMP);
    inc = (ph == 4 && !(sticky && op == HLT)) || (ph == 6 && op == SKZ && z) ||
          (ph == 7 && op == JMP);
    de  = (ph >= 6) && (op == STO);
    hl  = (ph == 4) && (op == HLT);
    return {rd, wr, ir, ac, pc, inc, de, hl};
  endfunction

  task automatic model_step(inout int ph, inout bit hl, input bit sticky,
                            input logic [2:0] op, input logic r);
    if (r) begin
      ph = 0;
      hl = 1'b0;
    end else if (hl) begin
      ph = ph;
    end else if (sticky && ph == 4 && op == HLT) begin
      hl = 1'b1;
    end else begin
      ph = (ph + 1) % 8;
    end
  endtask

  task automatic check_one(input string tag, input logic [2:0] phase_o,
                           input logic [7:0] strobes_o, input int ph, input bit hl,
                           input bit sticky);
    logic [2:0] eph;
    logic [7:0] est;
    eph = ph[2:0];
    est = expect_strobes(ph, op_r, zero_r, hl, sticky);
    compared++;
    assert (phase_o === eph) else begin
      mismatched++;
      $error("FAIL %s_phase observed=%0d expected=%0d", tag, phase_o, eph);
    end
    compared++;
    assert (strobes_o === est) else begin
      mismatched++;
      $error("FAIL %s_strobes phase=%0d op=%0d zero=%0b observed=%b expected=%b",
             tag, eph, op_r, zero_r, strobes_o, est);
    end
    compared++;
    assert (!(strobes_o[7] && strobes_o[6])) else begin
      mismatched++;
      $error("FAIL %s_rd_wr_exclusive observed=%b expected=no rd with wr", tag, strobes_o);
    end
  endtask

  // One clock: apply inputs, check both instances mid-cycle, then advance the models.
  task automatic cycle(input logic [2:0] op, input logic z, input logic r);
    op_r   = op;
    zero_r = z;
    rst    = r;
    #1;
    check_one("sticky", bus_s.phase,
              {bus_s.mem_rd, bus_s.mem_wr, bus_s.load_ir, bus_s.load_ac,
               bus_s.load_pc, bus_s.inc_pc, bus_s.data_e, bus_s.halt}, ph_s, hl_s, 1'b1);
    check_one("nonsticky", bus_n.phase,
              {bus_n.mem_rd, bus_n.mem_wr, bus_n.load_ir, bus_n.load_ac,
               bus_n.load_pc, bus_n.inc_pc, bus_n.data_e, bus_n.halt}, ph_n, hl_n, 1'b0);
    @(posedge clk);
    model_step(ph_s, hl_s, 1'b1, op, r);
    model_step(ph_n, hl_n, 1'b0, op, r);
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) cycle(op, z, 1'b0);
  endtask

  initial begin
    logic [2:0] rop;
    compared   = 0;
    mismatched = 0;
    op_r       = ADD;
    zero_r     = 1'b0;
    rst        = 1'b1;
    ph_s       = 0;
    ph_n       = 0;
    hl_s       = 1'b0;
    hl_n       = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles, then the directed instruction walk.
    cycle(ADD, 1'b0, 1'b1);
    cycle(ADD, 1'b0, 1'b1);
    run_instr(ADD, 1'b0);
    run_instr(SKZ, 1'b1);
    run_instr(SKZ, 1'b0);
    run_instr(JMP, 1'b0);
    run_instr(STO, 1'b1);

    // Reset in ALU_OP of an LDA, then a full instruction resumes.
    for (int i = 0; i < 6; i++) cycle(LDA, 1'b0, 1'b0);
    cycle(LDA, 1'b0, 1'b1);
    run_instr(LDA, 1'b1);

    // Random instructions with per-cycle zero and occasional resets.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++)
        cycle(rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      if (rop == HLT) cycle(ADD, 1'b0, 1'b1);
    end

    // Sticky HLT: freeze for 20 cycles under changing inputs, then reset clears it.
    cycle(ADD, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(HLT, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(ADD, 1'(i % 2), 1'b0);
    cycle(ADD, 1'b1, 1'b1);
    run_instr(XOR, 1'b0);
    run_instr(AND, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
